// File: rtl/fetch_pc_ctrl_if.sv
// Fetch PC controller bus: decode-side feedback and events in, fetch PC and
// status out. The controller owns the master side; its environment the slave.

`ifndef PC_SIZE
`define PC_SIZE 16
`endif

interface fetch_pc_ctrl_if #(
    parameter int PC_W = `PC_SIZE
);
    // Fetch-side control
    logic            i_stall;
    logic            i_pred_override;
    logic [PC_W-1:0] i_pred_target;

    // Decode-side instruction and branch feedback
    logic            i_dec_valid;
    logic [PC_W-1:0] i_dec_pc;
    logic            i_fb_branch;
    logic            i_fb_predict_taken;
    logic            i_fb_feedback_taken;
    logic [PC_W-1:0] i_fb_predict_target;
    logic [PC_W-1:0] i_fb_feedback_target;
    logic            i_halt;
    logic            i_interrupt;
    logic [3:0]      i_int_code;

    // Fetch PC and status
    logic [PC_W-1:0] o_pc;
    logic            o_instr_valid;
    logic            o_flush;
    logic            o_halted;
    logic [PC_W-1:0] o_epc;
    logic [15:0]     o_fetch_cnt;

    modport master (
        input  i_stall, i_pred_override, i_pred_target,
        input  i_dec_valid, i_dec_pc, i_fb_branch, i_fb_predict_taken,
        input  i_fb_feedback_taken, i_fb_predict_target, i_fb_feedback_target,
        input  i_halt, i_interrupt, i_int_code,
        output o_pc, o_instr_valid, o_flush, o_halted, o_epc, o_fetch_cnt
    );

    modport slave (
        output i_stall, i_pred_override, i_pred_target,
        output i_dec_valid, i_dec_pc, i_fb_branch, i_fb_predict_taken,
        output i_fb_feedback_taken, i_fb_predict_target, i_fb_feedback_target,
        output i_halt, i_interrupt, i_int_code,
        input  o_pc, o_instr_valid, o_flush, o_halted, o_epc, o_fetch_cnt
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the fetch PC register. Each cycle it picks one
// next PC from (highest first) mispredict repair, software interrupt vector,
// halt, stall hold, predictor override, sequential increment. Redirects kill
// the wrong-path fetch combinationally and land on o_pc one cycle later.

`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module fetch_pc_ctrl #(
    parameter int              PC_W     = `PC_SIZE,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] INT_BASE = PC_W'(16'h0010)
) (
    input  logic             clk,
    input  logic             n_rst,
    fetch_pc_ctrl_if.master  bus
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] epc_q, epc_d;
    logic [15:0]     cnt_q;

    logic            running;
    logic            ev;
    logic            dir_wrong;
    logic            tgt_wrong;
    logic            mispred;
    logic            int_take;
    logic            halt_take;
    logic            flush;
    logic            instr_valid;
    logic            fetch_accept;
    logic [PC_W-1:0] dec_pc_inc;
    logic [PC_W-1:0] fix_pc;
    logic [PC_W-1:0] int_pc;

    // Decode-event qualification, mispredict detection and redirect targets
    always_comb begin
        // NOTE: every signal written in an always_comb gets a value on every
        // path (here unconditionally); a missing default infers a latch.
        running    = (state_q == RUN);
        ev         = running & bus.i_dec_valid & ~bus.i_stall;
        dir_wrong  = bus.i_fb_predict_taken != bus.i_fb_feedback_taken;
        tgt_wrong  = bus.i_fb_feedback_taken &
                     (bus.i_fb_predict_target != bus.i_fb_feedback_target);
        mispred    = ev & bus.i_fb_branch & (dir_wrong | tgt_wrong);
        // Mispredict outranks an (illegal) simultaneous interrupt/halt, and
        // interrupt outranks halt.
        int_take   = ev & bus.i_interrupt & ~mispred;
        halt_take  = ev & bus.i_halt & ~mispred & ~bus.i_interrupt;
        dec_pc_inc = bus.i_dec_pc + PC_W'(1);
        fix_pc     = bus.i_fb_feedback_taken ? bus.i_fb_feedback_target : dec_pc_inc;
        int_pc     = INT_BASE + PC_W'(bus.i_int_code);
    end

    // Fetch-side status: flush and valid are forced low while reset is held
    always_comb begin
        flush        = n_rst & (mispred | (ev & (bus.i_interrupt | bus.i_halt)));
        instr_valid  = n_rst & running & ~flush;
        fetch_accept = instr_valid & ~bus.i_stall;
    end

    // Next-state / next-PC selection, one source per cycle
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        if (state_q == RUN) begin
            if (mispred) begin
                pc_d = fix_pc;
            end else if (int_take) begin
                pc_d  = int_pc;
                epc_d = dec_pc_inc;
            end else if (halt_take) begin
                state_d = HALTED;
            end else if (bus.i_stall) begin
                pc_d = pc_q;
            end else if (bus.i_pred_override) begin
                pc_d = bus.i_pred_target;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    // State, PC and return-PC registers
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!n_rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    // Saturating count of fetches accepted by the fetch register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (fetch_accept && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // Output drive
    assign bus.o_pc          = pc_q;
    assign bus.o_instr_valid = instr_valid;
    assign bus.o_flush       = flush;
    assign bus.o_halted      = (state_q == HALTED);
    assign bus.o_epc         = epc_q;
    assign bus.o_fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl (PC_W=16, RESET_PC=0, INT_BASE=0x0010).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.

module tb_fetch_pc_ctrl;

    localparam int PC_W = 16;

    logic clk;
    logic n_rst;
    int   total;
    int   bad;

    fetch_pc_ctrl_if #(.PC_W(PC_W)) bus ();

    fetch_pc_ctrl #(
        .PC_W     (PC_W),
        .RESET_PC (16'h0000),
        .INT_BASE (16'h0010)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_stall              = 1'b0;
        bus.i_pred_override      = 1'b0;
        bus.i_pred_target        = '0;
        bus.i_dec_valid          = 1'b0;
        bus.i_dec_pc             = '0;
        bus.i_fb_branch          = 1'b0;
        bus.i_fb_predict_taken   = 1'b0;
        bus.i_fb_feedback_taken  = 1'b0;
        bus.i_fb_predict_target  = '0;
        bus.i_fb_feedback_target = '0;
        bus.i_halt               = 1'b0;
        bus.i_interrupt          = 1'b0;
        bus.i_int_code           = '0;
    endtask

    task automatic set_branch(input logic [15:0] dec_pc, input logic pt, input logic ft,
                              input logic [15:0] ptgt, input logic [15:0] ftgt);
        bus.i_dec_valid          = 1'b1;
        bus.i_dec_pc             = dec_pc;
        bus.i_fb_branch          = 1'b1;
        bus.i_fb_predict_taken   = pt;
        bus.i_fb_feedback_taken  = ft;
        bus.i_fb_predict_target  = ptgt;
        bus.i_fb_feedback_target = ftgt;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_rst = 1'b0;
        clear_inputs();

        // Reset state
        #3;
        check("rst_pc", bus.o_pc, 32'h0);
        check("rst_valid", bus.o_instr_valid, 32'h0);
        check("rst_flush", bus.o_flush, 32'h0);
        check("rst_halted", bus.o_halted, 32'h0);
        check("rst_epc", bus.o_epc, 32'h0);
        check("rst_cnt", bus.o_fetch_cnt, 32'h0);

        // Free run from RESET_PC
        step();
        n_rst = 1'b1;
        #1;
        check("run_valid", bus.o_instr_valid, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("run_pc", bus.o_pc, 32'(i));
            step();
        end
        check("run_pc4", bus.o_pc, 32'h4);
        check("run_cnt4", bus.o_fetch_cnt, 32'h4);

        // Reset mid-run is immediate
        n_rst = 1'b0;
        #1;
        check("midrst_pc", bus.o_pc, 32'h0);
        check("midrst_valid", bus.o_instr_valid, 32'h0);
        check("midrst_cnt", bus.o_fetch_cnt, 32'h0);
        n_rst = 1'b1;

        // Advance to pc=5
        for (int i = 0; i < 5; i++) step();
        check("adv_pc5", bus.o_pc, 32'h5);

        // Override while stalled holds; override alone redirects
        bus.i_pred_override = 1'b1;
        bus.i_pred_target   = 16'd20;
        bus.i_stall         = 1'b1;
        step();
        check("stall_pc", bus.o_pc, 32'h5);
        check("stall_cnt", bus.o_fetch_cnt, 32'h5);
        bus.i_stall = 1'b0;
        step();
        check("ovr_pc", bus.o_pc, 32'd20);
        check("ovr_cnt", bus.o_fetch_cnt, 32'h6);

        // Mispredict: predicted not-taken, resolved taken to 40 (override ignored)
        bus.i_pred_target = 16'd99;
        set_branch(16'd8, 1'b0, 1'b1, 16'd0, 16'd40);
        #1;
        check("mp1_flush", bus.o_flush, 32'h1);
        check("mp1_valid", bus.o_instr_valid, 32'h0);
        step();
        clear_inputs();
        #1;
        check("mp1_pc", bus.o_pc, 32'd40);
        check("mp1_valid_after", bus.o_instr_valid, 32'h1);
        check("mp1_cnt", bus.o_fetch_cnt, 32'h6);

        // Predicted taken to 40, resolved not-taken -> dec_pc+1
        set_branch(16'd8, 1'b1, 1'b0, 16'd40, 16'd0);
        step();
        check("mp2_pc", bus.o_pc, 32'd9);

        // Taken both, wrong target
        set_branch(16'd8, 1'b1, 1'b1, 16'd40, 16'd44);
        step();
        check("mp3_pc", bus.o_pc, 32'd44);

        // Correct prediction: no flush, sequential
        set_branch(16'd8, 1'b1, 1'b1, 16'd40, 16'd40);
        #1;
        check("ok_flush", bus.o_flush, 32'h0);
        step();
        check("ok_pc", bus.o_pc, 32'd45);

        // Non-branch with mismatched feedback fields is not a mispredict
        set_branch(16'd8, 1'b0, 1'b1, 16'd0, 16'd40);
        bus.i_fb_branch = 1'b0;
        #1;
        check("nb_flush", bus.o_flush, 32'h0);
        step();
        clear_inputs();
        check("nb_pc", bus.o_pc, 32'd46);
        check("nb_cnt", bus.o_fetch_cnt, 32'h8);

        // Interrupt held under stall for 3 cycles, fires once after release
        bus.i_dec_valid = 1'b1;
        bus.i_dec_pc    = 16'd12;
        bus.i_interrupt = 1'b1;
        bus.i_int_code  = 4'd3;
        bus.i_stall     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("int_stall_flush", bus.o_flush, 32'h0);
            check("int_stall_pc", bus.o_pc, 32'd46);
            step();
        end
        check("int_stall_epc", bus.o_epc, 32'h0);
        bus.i_stall = 1'b0;
        #1;
        check("int_flush", bus.o_flush, 32'h1);
        step();
        clear_inputs();
        check("int_pc", bus.o_pc, 32'h0013);
        check("int_epc", bus.o_epc, 32'd13);
        step();
        check("int_once_pc", bus.o_pc, 32'h0014);
        check("int_cnt", bus.o_fetch_cnt, 32'h9);

        // PC wrap at 16'hFFFF
        bus.i_pred_override = 1'b1;
        bus.i_pred_target   = 16'hFFFF;
        step();
        clear_inputs();
        check("wrap_pre", bus.o_pc, 32'hFFFF);
        step();
        check("wrap_pc", bus.o_pc, 32'h0);

        // dec_pc+1 wrap on not-taken repair
        set_branch(16'hFFFF, 1'b1, 1'b0, 16'd5, 16'd0);
        step();
        clear_inputs();
        check("wrap_fix", bus.o_pc, 32'h0);

        // Mispredict together with halt: mispredict wins
        set_branch(16'd50, 1'b0, 1'b1, 16'd0, 16'd100);
        bus.i_halt = 1'b1;
        step();
        clear_inputs();
        check("mph_pc", bus.o_pc, 32'd100);
        check("mph_halted", bus.o_halted, 32'h0);

        // Halt accepted, then ignore everything for 10 cycles
        bus.i_dec_valid = 1'b1;
        bus.i_dec_pc    = 16'd99;
        bus.i_halt      = 1'b1;
        #1;
        check("halt_flush", bus.o_flush, 32'h1);
        step();
        clear_inputs();
        bus.i_pred_override = 1'b1;
        bus.i_pred_target   = 16'd7;
        set_branch(16'd3, 1'b0, 1'b1, 16'd0, 16'd200);
        bus.i_interrupt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("hlt_halted", bus.o_halted, 32'h1);
            check("hlt_pc", bus.o_pc, 32'd100);
            check("hlt_valid", bus.o_instr_valid, 32'h0);
            check("hlt_flush", bus.o_flush, 32'h0);
            step();
        end
        check("hlt_cnt", bus.o_fetch_cnt, 32'd11);
        check("hlt_epc", bus.o_epc, 32'd13);

        // Reset leaves HALTED; flush stays low while reset held despite events
        bus.i_interrupt = 1'b0;
        n_rst = 1'b0;
        #1;
        check("rst2_halted", bus.o_halted, 32'h0);
        check("rst2_flush", bus.o_flush, 32'h0);
        check("rst2_valid", bus.o_instr_valid, 32'h0);
        check("rst2_pc", bus.o_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
